// File: rtl/div_ctrl_if.sv
// EX <-> divider handshake bundle.
// EX drives the request side; the divider answers with result/ready/stall.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               div_start;
  logic               div_signed;
  logic [WIDTH-1:0]   div_op1;
  logic [WIDTH-1:0]   div_op2;
  logic               div_annul;
  logic [2*WIDTH-1:0] div_result;
  logic               div_ready;
  logic               stallreq_div;

  modport master (
    output div_start,
    output div_signed,
    output div_op1,
    output div_op2,
    output div_annul,
    input  div_result,
    input  div_ready,
    input  stallreq_div
  );

  modport slave (
    input  div_start,
    input  div_signed,
    input  div_op1,
    input  div_op2,
    input  div_annul,
    output div_result,
    output div_ready,
    output stallreq_div
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider for DIV/DIVU in EX.
// Result is {remainder, quotient}, one bit per cycle.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*W:0]   acc;
  logic [2*W:0]   sh;
  logic [2*W:0]   acc_nxt;
  logic [W+1:0]   tmp;
  logic [W-1:0]   dvs;
  logic [W-1:0]   mag1;
  logic [W-1:0]   mag2;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;
  logic           neg1;
  logic           neg2;
  logic           s1;
  logic           s2;
  logic [2*W-1:0] result;
  logic           ready;

  assign neg1 = bus.div_signed & bus.div_op1[W-1];
  assign neg2 = bus.div_signed & bus.div_op2[W-1];
  assign mag1 = neg1 ? -bus.div_op1 : bus.div_op1;
  assign mag2 = neg2 ? -bus.div_op2 : bus.div_op2;

  // Trial subtract on the shifted {rem, dividend}; a borrow restores.
  assign sh      = acc << 1;
  assign tmp     = {1'b0, sh[2*W:W]} - {2'b0, dvs};
  assign acc_nxt = tmp[W+1] ? sh
                 : {tmp[W:0], sh[W-1:1], 1'b1};

  assign quo   = acc_nxt[W-1:0];
  assign rem   = acc_nxt[2*W-1:W];
  assign q_fix = (s1 ^ s2) ? -quo : quo;
  assign r_fix = s1 ? -rem : rem;

  assign bus.div_result   = result;
  assign bus.div_ready    = ready;
  assign bus.stallreq_div = bus.div_start
                          & ~ready
                          & ~bus.div_annul;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      dvs    <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.div_start && !bus.div_annul) begin
            s1  <= neg1;
            s2  <= neg2;
            acc <= {{(W+1){1'b0}}, mag1};
            dvs <= mag2;
            cnt <= '0;
            if (bus.div_op2 == '0)
              state <= BYZERO;
            else
              state <= ON;
          end
        end
        BYZERO: begin
          if (bus.div_annul) begin
            state <= IDLE;
          end else begin
            state  <= END;
            result <= '0;
            ready  <= 1'b1;
          end
        end
        ON: begin
          if (bus.div_annul) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W-1)) begin
              state  <= END;
              result <= {r_fix, q_fix};
              ready  <= 1'b1;
            end
          end
        end
        END: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: latency, sign rules,
// divide-by-zero, annul, reset abort and back-to-back.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(32)) bus ();

  div_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] sb[$];
  logic [63:0] last_res = 64'h0;

  function automatic logic [63:0] model(
    input bit s, input logic [31:0] a, input logic [31:0] b
  );
    logic [31:0] ma, mb, q, r;
    if (b == 32'h0) return 64'h0;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    q  = ma / mb;
    r  = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  // Caller is positioned at a negedge with the divider idle.
  task automatic run_div(
    input bit s, input logic [31:0] a, input logic [31:0] b,
    input logic [63:0] exp, input int lat, input string nm
  );
    int          n;
    bit          stall_ok;
    logic [63:0] e;
    bus.div_start  = 1'b1;
    bus.div_signed = s;
    bus.div_op1    = a;
    bus.div_op2    = b;
    bus.div_annul  = 1'b0;
    sb.push_back(exp);
    #1;
    vectors++;
    if (bus.stallreq_div !== 1'b1) begin
      miscompares++;
      $display("FAIL %s stall_at_req got %b want 1", nm, bus.stallreq_div);
    end
    stall_ok = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    bus.div_op1    = $urandom;
    bus.div_op2    = $urandom;
    bus.div_signed = ~s;
    while (n < 60) begin
      @(negedge clk);
      if (bus.div_ready === 1'b1) break;
      if (bus.stallreq_div !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      n++;
    end
    e = sb.pop_front();
    vectors++;
    if (bus.div_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s timeout got no ready after %0d edges want %0d", nm, n, lat);
    end else begin
      vectors++;
      if (n != lat) begin
        miscompares++;
        $display("FAIL %s latency got %0d want %0d", nm, n, lat);
      end
      vectors++;
      if (!stall_ok) begin
        miscompares++;
        $display("FAIL %s stall_hold got drop want held", nm);
      end
      vectors++;
      if (bus.div_result !== e) begin
        miscompares++;
        $display("FAIL %s result got %h want %h", nm, bus.div_result, e);
      end
      vectors++;
      if (bus.stallreq_div !== 1'b0) begin
        miscompares++;
        $display("FAIL %s stall_at_ready got %b want 0", nm, bus.stallreq_div);
      end
    end
    last_res = e;
    bus.div_start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.div_ready !== 1'b0 || bus.div_result !== e) begin
      miscompares++;
      $display("FAIL %s pulse_hold got rdy=%b res=%h want rdy=0 res=%h",
               nm, bus.div_ready, bus.div_result, e);
    end
  endtask

  task automatic no_ready_window(input int cycles, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.div_ready !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen || bus.div_result !== last_res) begin
      miscompares++;
      $display("FAIL %s quiet got ready=%b res=%h want ready=0 res=%h",
               nm, seen, bus.div_result, last_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_op1    = 32'h0;
    bus.div_op2    = 32'h0;
    bus.div_annul  = 1'b0;
    #1;
    vectors++;
    if (bus.div_result !== 64'h0 || bus.div_ready !== 1'b0
        || bus.stallreq_div !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state got res=%h rdy=%b stall=%b want 0/0/0",
               bus.div_result, bus.div_ready, bus.stallreq_div);
    end
    bus.div_start = 1'b1;
    #1;
    vectors++;
    if (bus.stallreq_div !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_stall got %b want 1", bus.stallreq_div);
    end
    @(negedge clk);
    bus.div_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
  endtask

  task automatic test_signed();
    run_div(1'b1, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2");
    run_div(1'b1, 32'd7, -32'sd2, {32'h00000001, 32'hFFFFFFFD}, 33, "div_7_m2");
  endtask

  task automatic test_byzero();
    run_div(1'b1, 32'h1234, 32'h0, 64'h0, 2, "div_by_zero");
    run_div(1'b0, 32'd5, 32'd3, {32'd2, 32'd1}, 33, "divu_5_3");
    run_div(1'b0, 32'hFFFF, 32'h0, 64'h0, 2, "divu_by_zero");
  endtask

  task automatic test_overflow();
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF,
            {32'h0, 32'h80000000}, 33, "div_ovf");
    run_div(1'b0, 32'h80000000, 32'hFFFFFFFF,
            {32'h80000000, 32'h0}, 33, "divu_ovf");
  endtask

  task automatic test_annul();
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_op1    = 32'd50;
    bus.div_op2    = 32'd5;
    bus.div_annul  = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.div_annul = 1'b1;
    #1;
    vectors++;
    if (bus.stallreq_div !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_stall got %b want 0", bus.stallreq_div);
    end
    @(negedge clk);
    bus.div_annul = 1'b0;
    bus.div_start = 1'b0;
    no_ready_window(40, "annul_on");
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "divu_9_3");
  endtask

  task automatic test_annul_idle();
    bus.div_start  = 1'b1;
    bus.div_annul  = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_op1    = 32'd8;
    bus.div_op2    = 32'd2;
    repeat (3) @(negedge clk);
    bus.div_start = 1'b0;
    bus.div_annul = 1'b0;
    no_ready_window(40, "annul_idle");
  endtask

  task automatic test_rst_mid();
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_op1    = 32'd1000;
    bus.div_op2    = 32'd3;
    bus.div_annul  = 1'b0;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.div_result !== 64'h0 || bus.div_ready !== 1'b0
        || bus.stallreq_div !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid got res=%h rdy=%b stall=%b want 0/0/1",
               bus.div_result, bus.div_ready, bus.stallreq_div);
    end
    last_res = 64'h0;
    @(negedge clk);
    bus.div_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    no_ready_window(40, "rst_mid");
    run_div(1'b0, 32'd15, 32'd4, {32'd3, 32'd3}, 33, "divu_15_4");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    bit          s;
    for (int i = 0; i < 6; i++) begin
      s = i[0];
      a = $urandom;
      b = (i == 3) ? 32'h0 : ($urandom >> (i * 5));
      if (b == 32'h0 && i != 3) b = 32'd1;
      run_div(s, a, b, model(s, a, b), (b == 32'h0) ? 2 : 33, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_byzero();
    test_overflow();
    test_annul();
    test_annul_idle();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
